// File: rtl/l15_pico_req_ctrl_pkg.sv
// Shared definitions for the picorv32 -> L1.5 request controller.
//   ctrl_state_e : controller FSM states
//   MSG_DATA_SIZE_* : L1.5 request size codes
//   CTRL_ERR_*   : bit positions inside the sticky ctrl_err flags
//   ctrl_dbg_t   : debug view of controller internals (state, watchdog, ...)
package l15_pico_req_ctrl_pkg;

  typedef enum logic [2:0] {
    SLEEP = 3'd0,  // core held in reset until wakeup
    IDLE  = 3'd1,  // waiting for a core request
    ISSUE = 3'd2,  // request presented to L1.5, waiting for ack
    WAIT  = 3'd3,  // request accepted, waiting for response
    RESP  = 3'd4,  // one-cycle completion to the core
    ERR   = 3'd5   // illegal strobe, one-cycle completion, nothing issued
  } ctrl_state_e;

  localparam logic [2:0] MSG_DATA_SIZE_1B = 3'b001;
  localparam logic [2:0] MSG_DATA_SIZE_2B = 3'b010;
  localparam logic [2:0] MSG_DATA_SIZE_4B = 3'b011;

  localparam int CTRL_ERR_STRB    = 0;
  localparam int CTRL_ERR_TIMEOUT = 1;

  localparam int WATCHDOG_W = 16;

  typedef struct packed {
    ctrl_state_e             state;
    logic                    drop_pending;
    logic                    req_instr;     // latched pico_mem_instr
    logic [1:0]              pico_addr_lo;  // latched raw pico_mem_addr[1:0]
    logic [WATCHDOG_W-1:0]   watchdog;
  } ctrl_dbg_t;

endpackage

// File: rtl/l15_pico_wstrb_decode.sv
// Combinational translation of a picorv32 byte-strobe pattern into an L1.5
// request shape.
//   wstrb    in  4 : pico byte strobes (0 = load)
//   is_store out 1 : request is a store
//   size     out 3 : MSG_DATA_SIZE_* code
//   addr_lo  out 2 : byte offset to place in address bits [1:0]
//   illegal  out 1 : pattern cannot be expressed as a single L1.5 access
module l15_pico_wstrb_decode
  import l15_pico_req_ctrl_pkg::*;
(
  input  logic [3:0] wstrb,
  output logic       is_store,
  output logic [2:0] size,
  output logic [1:0] addr_lo,
  output logic       illegal
);

  always_comb begin
    is_store = 1'b1;
    size     = MSG_DATA_SIZE_1B;
    addr_lo  = 2'b00;
    illegal  = 1'b0;
    case (wstrb)
      4'b0000: begin
        is_store = 1'b0;
        size     = MSG_DATA_SIZE_4B;
      end
      4'b1111: size = MSG_DATA_SIZE_4B;
      4'b0011: size = MSG_DATA_SIZE_2B;
      4'b1100: begin
        size    = MSG_DATA_SIZE_2B;
        addr_lo = 2'b10;
      end
      4'b0001: addr_lo = 2'b00;
      4'b0010: addr_lo = 2'b01;
      4'b0100: addr_lo = 2'b10;
      4'b1000: addr_lo = 2'b11;
      default: begin
        is_store = 1'b0;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/l15_pico_req_ctrl.sv
// Sequences picorv32 memory requests onto the L1.5 request/response path,
// one transaction outstanding at a time. Holds the core in reset until the
// wakeup interrupt, and abandons transactions whose response never arrives.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   pico_mem_*               picorv32 native memory interface
//   pico_resetn              core reset (active-low), released on wakeup
//   ctrl_l15_req_*           L1.5 request (val/is_store/address/size/data)
//   l15_ctrl_req_ack         L1.5 accepted the request
//   l15_ctrl_resp_val/rdata  L1.5 response
//   l15_ctrl_wakeup          wakeup interrupt pulse
//   ctrl_err                 sticky flags: [0] illegal strobe, [1] timeout
//   ctrl_dbg                 debug view of FSM state, watchdog, drop flag
//
// Handshakes: the core holds pico_mem_valid and its fields until it sees
// pico_mem_ready for one cycle. ctrl_l15_req_val and all request fields stay
// stable until l15_ctrl_req_ack is sampled high; l15_ctrl_resp_val is a
// single-cycle strobe with no back-pressure.
module l15_pico_req_ctrl
  import l15_pico_req_ctrl_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] ADDR_HI        = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pico_mem_valid,
  input  logic        pico_mem_instr,
  input  logic [31:0] pico_mem_addr,
  input  logic [31:0] pico_mem_wdata,
  input  logic [3:0]  pico_mem_wstrb,
  output logic        pico_mem_ready,
  output logic [31:0] pico_mem_rdata,
  output logic        pico_resetn,
  output logic        ctrl_l15_req_val,
  output logic        ctrl_l15_req_is_store,
  output logic [39:0] ctrl_l15_req_address,
  output logic [2:0]  ctrl_l15_req_size,
  output logic [31:0] ctrl_l15_req_data,
  input  logic        l15_ctrl_req_ack,
  input  logic        l15_ctrl_resp_val,
  input  logic [31:0] l15_ctrl_resp_rdata,
  input  logic        l15_ctrl_wakeup,
  output logic [1:0]  ctrl_err,
  output ctrl_dbg_t   ctrl_dbg
);

  localparam logic [WATCHDOG_W-1:0] WDOG_LAST = WATCHDOG_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e           state_q, state_d;
  logic                  resetn_q, resetn_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  req_val_q, req_val_d;
  logic                  is_store_q, is_store_d;
  logic [39:0]           addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            err_q, err_d;
  logic                  drop_q, drop_d;
  logic [WATCHDOG_W-1:0] wdog_q, wdog_d;
  logic                  instr_q, instr_d;
  logic [1:0]            addr_lo_q, addr_lo_d;

  logic       dec_is_store;
  logic [2:0] dec_size;
  logic [1:0] dec_addr_lo;
  logic       dec_illegal;

  l15_pico_wstrb_decode u_wstrb_decode (
    .wstrb    (pico_mem_wstrb),
    .is_store (dec_is_store),
    .size     (dec_size),
    .addr_lo  (dec_addr_lo),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLEEP;
      resetn_q   <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      req_val_q  <= 1'b0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      data_q     <= '0;
      err_q      <= '0;
      drop_q     <= 1'b0;
      wdog_q     <= '0;
      instr_q    <= 1'b0;
      addr_lo_q  <= '0;
    end else begin
      state_q    <= state_d;
      resetn_q   <= resetn_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      req_val_q  <= req_val_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      data_q     <= data_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      wdog_q     <= wdog_d;
      instr_q    <= instr_d;
      addr_lo_q  <= addr_lo_d;
    end
  end

  // Next-state and next-output logic. Every output is computed one cycle
  // ahead here so the ports come straight from flops.
  always_comb begin
    state_d    = state_q;
    resetn_d   = resetn_q;
    ready_d    = 1'b0;
    rdata_d    = '0;
    req_val_d  = req_val_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    size_d     = size_q;
    data_d     = data_q;
    err_d      = err_q;
    drop_d     = drop_q;
    wdog_d     = wdog_q;
    instr_d    = instr_q;
    addr_lo_d  = addr_lo_q;

    // A late response from an abandoned transaction may turn up at any point
    // outside WAIT; it settles the outstanding drop.
    if (state_q != WAIT && l15_ctrl_resp_val) begin
      drop_d = 1'b0;
    end

    case (state_q)
      SLEEP: begin
        if (l15_ctrl_wakeup) begin
          state_d  = IDLE;
          resetn_d = 1'b1;
        end
      end
      IDLE: begin
        if (pico_mem_valid) begin
          instr_d   = pico_mem_instr;
          addr_lo_d = pico_mem_addr[1:0];
          if (dec_illegal) begin
            state_d               = ERR;
            ready_d               = 1'b1;
            err_d[CTRL_ERR_STRB]  = 1'b1;
          end else begin
            state_d    = ISSUE;
            req_val_d  = 1'b1;
            is_store_d = dec_is_store;
            size_d     = dec_size;
            addr_d     = {ADDR_HI, pico_mem_addr[31:2], dec_addr_lo};
            data_d     = pico_mem_wdata;
          end
        end
      end
      ISSUE: begin
        if (l15_ctrl_req_ack) begin
          state_d   = WAIT;
          req_val_d = 1'b0;
          wdog_d    = '0;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (l15_ctrl_resp_val && !drop_q) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = is_store_q ? 32'h0 : l15_ctrl_resp_rdata;
        end else begin
          if (l15_ctrl_resp_val) begin
            drop_d = 1'b0;
          end
          // Timeout re-arms the drop even if a stale response was just eaten:
          // this transaction's own response is now owed.
          if (wdog_q == WDOG_LAST) begin
            state_d                  = RESP;
            ready_d                  = 1'b1;
            err_d[CTRL_ERR_TIMEOUT]  = 1'b1;
            drop_d                   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = SLEEP;
    endcase
  end

  assign pico_mem_ready        = ready_q;
  assign pico_mem_rdata        = rdata_q;
  assign pico_resetn           = resetn_q;
  assign ctrl_l15_req_val      = req_val_q;
  assign ctrl_l15_req_is_store = is_store_q;
  assign ctrl_l15_req_address  = addr_q;
  assign ctrl_l15_req_size     = size_q;
  assign ctrl_l15_req_data     = data_q;
  assign ctrl_err              = err_q;

  assign ctrl_dbg = '{state:        state_q,
                      drop_pending: drop_q,
                      req_instr:    instr_q,
                      pico_addr_lo: addr_lo_q,
                      watchdog:     wdog_q};

endmodule
